// File: rtl/change_dispenser.sv
// Coin-return sequencer: pays a cent amount as quarter/dime/nickel solenoid
// pulses, largest coin first, falling back to smaller coins when a hopper is empty.
module change_dispenser #(
  parameter int AMT_W        = 8,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [AMT_W-1:0] amount,
  input  logic             Q_empty,
  input  logic             D_empty,
  input  logic             N_empty,
  output logic             Q_out,
  output logic             D_out,
  output logic             N_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [AMT_W-1:0] remaining
);

  localparam int CNT_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] P_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] G_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_PULSE, S_GAP, S_DONE} state_t;
  typedef enum logic [1:0] {COIN_Q, COIN_D, COIN_N} coin_t;

  state_t           state, state_n;
  coin_t            coin, coin_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [AMT_W-1:0] rem_n;
  logic             err_n;
  logic [AMT_W-1:0] coin_val;

  always_comb begin
    case (coin)
      COIN_Q:  coin_val = AMT_W'(25);
      COIN_D:  coin_val = AMT_W'(10);
      default: coin_val = AMT_W'(5);
    endcase
  end

  always_comb begin
    state_n = state;
    coin_n  = coin;
    cnt_n   = cnt;
    rem_n   = remaining;
    err_n   = err;
    case (state)
      S_IDLE: begin
        if (start) begin
          rem_n = amount;
          if ((amount % AMT_W'(5)) != '0) begin
            err_n   = 1'b1;
            state_n = S_DONE;
          end else begin
            err_n   = 1'b0;
            state_n = S_SELECT;
          end
        end
      end
      S_SELECT: begin
        cnt_n = '0;
        if (remaining == '0) begin
          state_n = S_DONE;
        end else if (remaining >= AMT_W'(25) && !Q_empty) begin
          coin_n  = COIN_Q;
          state_n = S_PULSE;
        end else if (remaining >= AMT_W'(10) && !D_empty) begin
          coin_n  = COIN_D;
          state_n = S_PULSE;
        end else if (remaining >= AMT_W'(5) && !N_empty) begin
          coin_n  = COIN_N;
          state_n = S_PULSE;
        end else begin
          err_n   = 1'b1;
          state_n = S_DONE;
        end
      end
      S_PULSE: begin
        if (cnt == P_LAST) begin
          // Selection guaranteed remaining >= coin_val, so no underflow here.
          rem_n   = remaining - coin_val;
          cnt_n   = '0;
          state_n = (GAP_CYCLES == 0) ? S_SELECT : S_GAP;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt == G_LAST) state_n = S_SELECT;
        else               cnt_n   = cnt + CNT_W'(1);
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they align with the state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= S_IDLE;
      coin      <= COIN_Q;
      cnt       <= '0;
      remaining <= '0;
      err       <= 1'b0;
      Q_out     <= 1'b0;
      D_out     <= 1'b0;
      N_out     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      coin      <= coin_n;
      cnt       <= cnt_n;
      remaining <= rem_n;
      err       <= err_n;
      Q_out     <= (state_n == S_PULSE) && (coin_n == COIN_Q);
      D_out     <= (state_n == S_PULSE) && (coin_n == COIN_D);
      N_out     <= (state_n == S_PULSE) && (coin_n == COIN_N);
      busy      <= (state_n != S_IDLE);
      done      <= (state_n == S_DONE);
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: stimulus queues expected transaction
// results; a monitor pops and compares them on each done pulse.
module tb_change_dispenser;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       start = 1'b0;
  logic [7:0] amount = '0;
  logic       Q_empty = 1'b0, D_empty = 1'b0, N_empty = 1'b0;
  logic       Q_out, D_out, N_out, busy, done, err;
  logic [7:0] remaining;

  change_dispenser #(.AMT_W(8), .PULSE_CYCLES(4), .GAP_CYCLES(2)) dut (
    .CLK(CLK), .RST(RST), .start(start), .amount(amount),
    .Q_empty(Q_empty), .D_empty(D_empty), .N_empty(N_empty),
    .Q_out(Q_out), .D_out(D_out), .N_out(N_out),
    .busy(busy), .done(done), .err(err), .remaining(remaining)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  typedef struct {
    int done_cyc;
    int rem;
    int err;
    int qc, dc, nc;
    int first;
  } exp_t;

  exp_t sbq[$];

  // Monitor: accumulate coin activity per transaction, compare on done.
  int   mq = 0, md = 0, mn = 0, mfirst = -1;
  exp_t me;
  always @(negedge CLK) begin
    if (Q_out || D_out || N_out) begin
      check("onehot", int'(Q_out) + int'(D_out) + int'(N_out), 1);
      if (mfirst < 0) mfirst = cyc;
    end
    if (Q_out) mq++;
    if (D_out) md++;
    if (N_out) mn++;
    if (done) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        me = sbq.pop_front();
        check("done_cycle", cyc, me.done_cyc);
        check("remaining", int'(remaining), me.rem);
        check("err", int'(err), me.err);
        check("q_cycles", mq, me.qc);
        check("d_cycles", md, me.dc);
        check("n_cycles", mn, me.nc);
        check("first_pulse", mfirst, me.first);
      end
      mq = 0; md = 0; mn = 0; mfirst = -1;
    end else if (!busy) begin
      mq = 0; md = 0; mn = 0; mfirst = -1;
    end
  end

  // Latencies are in cycles after the negedge that drives start (cycle 0).
  task automatic do_txn(input int a, input int lat, input int rem, input int e,
                        input int qn, input int dn, input int nn, input int f);
    exp_t x;
    int   s;
    @(negedge CLK);
    s      = cyc;
    start  = 1'b1;
    amount = 8'(a);
    x.done_cyc = s + lat;
    x.rem      = rem;
    x.err      = e;
    x.qc       = qn * 4;
    x.dc       = dn * 4;
    x.nc       = nn * 4;
    x.first    = (f < 0) ? -1 : s + f;
    sbq.push_back(x);
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (!busy) return;
    end
    check("idle_timeout", 1, 0);
  endtask

  initial begin
    int s;
    repeat (3) @(negedge CLK);
    check("rst_q", int'(Q_out), 0);
    check("rst_d", int'(D_out), 0);
    check("rst_n", int'(N_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_rem", int'(remaining), 0);
    RST = 1'b0;
    @(negedge CLK);

    do_txn(40, 23, 0, 0, 1, 1, 1, 2);   wait_idle();
    Q_empty = 1'b1;
    do_txn(30, 23, 0, 0, 0, 3, 0, 2);   wait_idle();
    Q_empty = 1'b0; N_empty = 1'b1;
    do_txn(15, 9, 5, 1, 0, 1, 0, 2);    wait_idle();
    N_empty = 1'b0;
    do_txn(7, 1, 7, 1, 0, 0, 0, -1);    wait_idle();
    repeat (3) @(negedge CLK);
    check("hold_err", int'(err), 1);
    check("hold_rem", int'(remaining), 7);
    do_txn(0, 2, 0, 0, 0, 0, 0, -1);    wait_idle();
    do_txn(65, 30, 0, 0, 2, 1, 1, 2);   wait_idle();
    D_empty = 1'b1;
    do_txn(20, 30, 0, 0, 0, 0, 4, 2);   wait_idle();
    Q_empty = 1'b1; N_empty = 1'b1;
    do_txn(25, 2, 25, 1, 0, 0, 0, -1);  wait_idle();
    Q_empty = 1'b0; D_empty = 1'b0; N_empty = 1'b0;

    // Reset during the second cycle of a quarter pulse.
    @(negedge CLK);
    s = cyc;
    start = 1'b1; amount = 8'd50;
    @(negedge CLK);
    start = 1'b0;
    repeat (2) @(negedge CLK);
    check("pre_rst_q", int'(Q_out), 1);
    RST = 1'b1;
    @(negedge CLK);
    check("mid_rst_cycle", cyc, s + 4);
    check("mid_rst_q", int'(Q_out), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_rem", int'(remaining), 0);
    RST = 1'b0;
    do_txn(25, 9, 0, 0, 1, 0, 0, 2);    wait_idle();

    // A start while busy must be ignored.
    do_txn(25, 9, 0, 0, 1, 0, 0, 2);
    @(negedge CLK);
    start = 1'b1; amount = 8'd10;
    @(negedge CLK);
    start = 1'b0;
    wait_idle();

    repeat (20) @(negedge CLK);
    check("sb_drain", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Coin-return sequencer for the vending-machine datapath. Accepts a change amount in cents from the transaction FSM and pays it out as quarter, dime and nickel solenoid pulses to the coin hoppers. It uses the largest coin first and falls back to smaller coins when a hopper reports empty. It is the payout counterpart of the coin-acceptance path and reports completion, residual amount and failure back to the main FSM.

## Interface
- AMT_W, 8: width of amount/remaining in cents
- PULSE_CYCLES, 4: solenoid pulse width in clocks (≥1)
- GAP_CYCLES, 2: idle clocks between coin pulses (≥0; 0 removes GAP state)

- CLK  in  1  clock, all logic on posedge
- RST  in  1  synchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- amount  in  AMT_W  change to pay, cents; sampled with start
- Q_empty, D_empty, N_empty  in  1 each  hopper empty flags
- Q_out, D_out, N_out  out  1 each  solenoid pulses (25¢, 10¢, 5¢)
- busy  out  1  transaction in progress
- done  out  1  one-cycle completion pulse
- err  out  1  change could not be fully paid; level, valid from done
- remaining  out  AMT_W  cents still owed

## Operation
- Reset (RST=1 at an edge): state IDLE, all coin outputs 0, busy=0, done=0, err=0, remaining=0. RST has priority over everything. A coin pulse in progress is truncated and remaining is not decremented for it.
- States: IDLE, SELECT, PULSE, GAP, DONE.
- IDLE: busy=0.
  - On start=1 with amount%5≠0: remaining←amount, err←1, go to DONE (no coins).
  - Otherwise: remaining←amount, err←0, go to SELECT.
- SELECT, 1 cycle. Empty flags are sampled only here. The first matching condition applies:
  - remaining=0 → DONE.
  - remaining≥25 and !Q_empty → coin=Q.
  - remaining≥10 and !D_empty → coin=D.
  - remaining≥5 and !N_empty → coin=N.
  - Else err←1, go to DONE.
  - On any coin selection, go to PULSE.
- PULSE: the selected coin output is 1 for exactly PULSE_CYCLES cycles; the other coin outputs are 0. On the last cycle, remaining←remaining−value. Then go to GAP, or to SELECT if GAP_CYCLES=0.
- GAP: all coin outputs 0 for GAP_CYCLES cycles, then SELECT.
- DONE, 1 cycle: done=1, then IDLE.
- busy=1 in SELECT, PULSE, GAP and DONE.
- start is ignored while not in IDLE.
- At most one coin output is high in any cycle.
- Subtraction never underflows, because selection guarantees remaining≥value.
- err and remaining hold their values in IDLE until the next accepted start.

## Timing
- Cycle k means the cycle after clock edge k.
- start is accepted at edge 0; busy=1 from cycle 1.
- Each coin costs 1+PULSE_CYCLES+GAP_CYCLES cycles.
- n coins, success: done in cycle n·(P+G+1)+2.
  - Defaults: 7n+2.
  - amount=0: done in cycle 2.
- Non-multiple-of-5 amount: done in cycle 1.
- The first coin pulse starts in cycle 2.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- After DONE, IDLE can accept a new start on the very next edge.

## Test plan
- amount=40, no hopper empty, defaults:
  - Q_out high in cycles 2–5, D_out high in 9–12, N_out high in 16–19.
  - done in cycle 23, remaining=0, err=0.
- amount=30 with Q_empty=1: three D pulses, done in cycle 23, err=0.
- amount=15 with N_empty=1: one D pulse, then err=1 and done in cycle 9, remaining=5.
- amount=7: done in cycle 1, err=1, remaining=7, no coin pulse. amount=0: done in cycle 2, err=0.
- RST during the 2nd cycle of a Q pulse (amount=50):
  - All outputs 0 and remaining=0 the next cycle, state IDLE.
  - A subsequent start with amount=25 pays one Q normally.
- start with amount=10 asserted while paying 25: ignored. Only one Q is paid, then done.
